// File: rtl/ksa_as_arb.sv
// Two-requester round-robin front end that shares one Kogge-Stone add/sub unit,
// with a one-entry result register. Define KSA_AS_ARB_OVF_EN to add the rsp_ovf output.

module ksa_as (
    input  logic [31:0] ain,
    input  logic [31:0] bin,
    input  logic        cin,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] bx;
    logic        c0;
    logic [31:0] gl [6];
    logic [31:0] pl [6];
    logic [32:0] carry;

    // Subtract is a + ~b + 1, so the inverted operand always carries in a one.
    assign bx    = sub ? ~bin : bin;
    assign c0    = sub | cin;
    assign gl[0] = ain & bx;
    assign pl[0] = ain ^ bx;

    for (genvar k = 0; k < 5; k++) begin : g_lvl
        localparam int unsigned D = 1 << k;
        localparam logic [31:0] LowMask = (32'd1 << D) - 32'd1;
        // Bits below D have no partner at this level: generate passes, propagate is kept.
        assign gl[k+1] = gl[k] | (pl[k] & (gl[k] << D));
        assign pl[k+1] = pl[k] & ((pl[k] << D) | LowMask);
    end

    assign carry = {gl[5] | (pl[5] & {32{c0}}), c0};
    assign sum   = pl[0] ^ carry[31:0];
    assign cout  = carry[32];
endmodule

module ksa_as_arb #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,
    input  logic        req_cin_0,
    input  logic        req_sub_0,
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,
    input  logic        req_cin_1,
    input  logic        req_sub_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_sum,
    output logic        rsp_cout
`ifdef KSA_AS_ARB_OVF_EN
    ,
    output logic        rsp_ovf
`endif
);
    typedef enum logic {StEmpty, StFull} state_e;

    state_e      state_q;
    logic        prio_q;
    logic        can_accept;
    logic        gnt_0;
    logic        gnt_1;
    logic        xfer;
    logic [31:0] mux_a;
    logic [31:0] mux_b;
    logic        mux_cin;
    logic        mux_sub;
    logic [31:0] alu_sum;
    logic        alu_cout;

    assign can_accept = (state_q == StEmpty) | rsp_ready;

    // prio_q = 0 means requester 0 wins a tie.
    assign gnt_0 = req_valid_0 & (~req_valid_1 | ~prio_q);
    assign gnt_1 = req_valid_1 & (~req_valid_0 | prio_q);

    assign req_ready_0 = gnt_0 & can_accept & ~rst;
    assign req_ready_1 = gnt_1 & can_accept & ~rst;
    assign xfer        = (req_valid_0 & req_ready_0) | (req_valid_1 & req_ready_1);

    assign mux_a   = gnt_1 ? req_a_1   : req_a_0;
    assign mux_b   = gnt_1 ? req_b_1   : req_b_0;
    assign mux_cin = gnt_1 ? req_cin_1 : req_cin_0;
    assign mux_sub = gnt_1 ? req_sub_1 : req_sub_0;

    ksa_as u_ksa_as (
        .ain  (mux_a),
        .bin  (mux_b),
        .cin  (mux_cin),
        .sub  (mux_sub),
        .sum  (alu_sum),
        .cout (alu_cout)
    );

`ifdef KSA_AS_ARB_OVF_EN
    logic mux_bx_msb;
    logic alu_ovf;

    assign mux_bx_msb = mux_sub ? ~mux_b[31] : mux_b[31];
    assign alu_ovf    = (mux_a[31] == mux_bx_msb) & (alu_sum[31] != mux_a[31]);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_ovf <= 1'b0;
        end else if (xfer) begin
            rsp_ovf <= alu_ovf;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StEmpty;
            prio_q   <= (RR_INIT != 0);
            rsp_id   <= 1'b0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (xfer) begin
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    // A drain with a simultaneous transfer stays full and reloads.
                    if (!xfer && rsp_ready) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
            if (xfer) begin
                prio_q   <= ~gnt_1;
                rsp_id   <= gnt_1;
                rsp_sum  <= alu_sum;
                rsp_cout <= alu_cout;
            end
        end
    end

    assign rsp_valid = (state_q == StFull);
endmodule

// File: tb/tb_ksa_as_arb.sv
// Scoreboard bench for ksa_as_arb: expectations queued at issue, compared as results drain.
module tb_ksa_as_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_0, req_ready_0, req_cin_0, req_sub_0;
    logic [31:0] req_a_0, req_b_0;
    logic        req_valid_1, req_ready_1, req_cin_1, req_sub_1;
    logic [31:0] req_a_1, req_b_1;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [31:0] rsp_sum;
`ifdef KSA_AS_ARB_OVF_EN
    logic        rsp_ovf;
`endif

    always #5 clk = ~clk;

    ksa_as_arb #(.RR_INIT(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_0 (req_valid_0),
        .req_ready_0 (req_ready_0),
        .req_a_0     (req_a_0),
        .req_b_0     (req_b_0),
        .req_cin_0   (req_cin_0),
        .req_sub_0   (req_sub_0),
        .req_valid_1 (req_valid_1),
        .req_ready_1 (req_ready_1),
        .req_a_1     (req_a_1),
        .req_b_1     (req_b_1),
        .req_cin_1   (req_cin_1),
        .req_sub_1   (req_sub_1),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_sum     (rsp_sum),
        .rsp_cout    (rsp_cout)
`ifdef KSA_AS_ARB_OVF_EN
        ,
        .rsp_ovf     (rsp_ovf)
`endif
    );

    typedef struct packed {
        logic        id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [31:0] bx;
        logic [32:0] r;
        bx = sub ? ~b : b;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else     r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        e.id   = id;
        e.sum  = r[31:0];
        e.cout = r[32];
        e.ovf  = (a[31] == bx[31]) && (r[31] != a[31]);
        return e;
    endfunction

    task automatic drive(input int n, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        if (n == 0) begin
            req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_cin_0 = cin; req_sub_0 = sub;
        end else begin
            req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_cin_1 = cin; req_sub_1 = sub;
        end
    endtask

    // Issue one operation, wait (bounded) for its transfer, then check latency-1 valid.
    task automatic send(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub);
        int waited;
        @(posedge clk); #1;
        drive(n, 1'b1, a, b, cin, sub);
        sb.push_back(model(n[0], a, b, cin, sub));
        waited = 0;
        @(negedge clk);
        while (!((n == 0) ? req_ready_0 : req_ready_1) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("xfer_in_budget", 64'(waited < 20), 1);
        @(posedge clk); #1;
        drive(n, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("lat1_valid", rsp_valid, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            check_eq("sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_eq("rsp_id", rsp_id, mon_e.id);
                check_eq("rsp_sum", rsp_sum, mon_e.sum);
                check_eq("rsp_cout", rsp_cout, mon_e.cout);
`ifdef KSA_AS_ARB_OVF_EN
                check_eq("rsp_ovf", rsp_ovf, mon_e.ovf);
`endif
            end
        end
    end

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(0, 1'b1, 32'd10, 32'd15, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("rst_valid", rsp_valid, 0);
        check_eq("rst_id", rsp_id, 0);
        check_eq("rst_sum", rsp_sum, 0);
        check_eq("rst_cout", rsp_cout, 0);
        check_eq("rst_ready0", req_ready_0, 0);
        check_eq("rst_ready1", req_ready_1, 0);
`ifdef KSA_AS_ARB_OVF_EN
        check_eq("rst_ovf", rsp_ovf, 0);
`endif
        // Single add, accepted in the first cycle out of reset.
        @(posedge clk); #1;
        rst = 1'b0;
        sb.push_back(model(1'b0, 32'd10, 32'd15, 1'b0, 1'b0));
        @(negedge clk);
        check_eq("first_ready0", req_ready_0, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("add_valid", rsp_valid, 1);

        // Wrap-around via r1; also hands priority back to r0.
        send(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);

        // Contention: r0 (priority) first, r1 on the very next cycle.
        @(posedge clk); #1;
        drive(0, 1'b1, 32'd20, 32'd5, 1'b0, 1'b1);
        drive(1, 1'b1, 32'd100, 32'd200, 1'b1, 1'b0);
        sb.push_back(model(1'b0, 32'd20, 32'd5, 1'b0, 1'b1));
        sb.push_back(model(1'b1, 32'd100, 32'd200, 1'b1, 1'b0));
        @(negedge clk);
        check_eq("cont_ready0", req_ready_0, 1);
        check_eq("cont_ready1_lo", req_ready_1, 0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("cont_ready1", req_ready_1, 1);
        check_eq("cont_valid", rsp_valid, 1);
        @(posedge clk); #1;
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("cont_valid2", rsp_valid, 1);

        // Subtract with borrow, then signed overflow.
        send(0, 32'd50, 32'd75, 1'b0, 1'b1);
        send(1, 32'h8000_0000, 32'd1, 1'b0, 1'b1);

        // Backpressure: result held, r1 stalled, then accepted as the drain happens.
        @(posedge clk); #1;
        drive(0, 1'b1, 32'd7, 32'd8, 1'b0, 1'b0);
        sb.push_back(model(1'b0, 32'd7, 32'd8, 1'b0, 1'b0));
        @(negedge clk);
        check_eq("bp_ready0", req_ready_0, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        drive(1, 1'b1, 32'd1000, 32'd24, 1'b0, 1'b0);
        sb.push_back(model(1'b1, 32'd1000, 32'd24, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_valid", rsp_valid, 1);
            check_eq("bp_id", rsp_id, 0);
            check_eq("bp_sum", rsp_sum, 15);
            check_eq("bp_cout", rsp_cout, 0);
            check_eq("bp_ready1", req_ready_1, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_accept1", req_ready_1, 1);
        check_eq("bp_valid_hold", rsp_valid, 1);
        @(posedge clk); #1;
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("bp_valid_next", rsp_valid, 1);

        // Reset while full: result discarded, priority back to r0.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(0, 32'd3, 32'd4, 1'b0, 1'b0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", rsp_valid, 0);
        check_eq("mid_rst_sum", rsp_sum, 0);
        @(posedge clk); #1;
        drive(0, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
        drive(1, 1'b1, 32'd5, 32'd6, 1'b0, 1'b0);
        sb.push_back(model(1'b0, 32'd1, 32'd2, 1'b0, 1'b0));
        sb.push_back(model(1'b1, 32'd5, 32'd6, 1'b0, 1'b0));
        @(negedge clk);
        check_eq("post_rst_nopulse", rsp_valid, 0);
        check_eq("post_rst_ready0", req_ready_0, 1);
        check_eq("post_rst_ready1", req_ready_1, 0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("post_rst_ready1b", req_ready_1, 1);
        @(posedge clk); #1;
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb.size(), 0);
        check_eq("idle_valid", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
